// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
// Optional macro IMEM_RESP_ERR_EN is consumed by imem_responder.
package imem_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSN_NOP = 32'h0000_0013;
  localparam int LAT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } imem_rsp_state_t;
endpackage

// File: rtl/imem_array.sv
// Word-addressed instruction RAM: combinational read, synchronous load.
// Reads in the load cycle return the old word.
import imem_pkg::*;

module imem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW = $clog2(DEPTH_WORDS)
) (
  input  logic            clk,
  input  logic [AW-1:0]   rd_idx_i,
  output logic [XLEN-1:0] rd_data_o,
  input  logic            ld_we,
  input  logic [AW-1:0]   ld_addr,
  input  logic [XLEN-1:0] ld_data
);

  logic [XLEN-1:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (ld_we) mem_q[ld_addr] <= ld_data;
  end

  assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/imem_responder.sv
// Single-outstanding imem target with fixed response latency.
// Define IMEM_RESP_ERR_EN to add imem_resp_err for bad addresses.
import imem_pkg::*;

module imem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY = 1,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            imem_req_valid,
  input  logic [XLEN-1:0] imem_req_addr,
  output logic            imem_req_ready,
  output logic            imem_resp_valid,
  output logic [XLEN-1:0] imem_resp_data,
  input  logic            imem_resp_ready,
  input  logic            ld_we,
  input  logic [AW-1:0]   ld_addr,
  input  logic [XLEN-1:0] ld_data
`ifdef IMEM_RESP_ERR_EN
  ,
  output logic            imem_resp_err
`endif
);

  imem_rsp_state_t state_q, state_d;
  logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [XLEN-1:0] rd_word, sel_word;
  logic fire, oor, mis;

  imem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW(AW)
  ) u_array (
    .clk(clk),
    .rd_idx_i(imem_req_addr[AW+1:2]),
    .rd_data_o(rd_word),
    .ld_we(ld_we),
    .ld_addr(ld_addr),
    .ld_data(ld_data)
  );

  assign oor = |imem_req_addr[XLEN-1:AW+2];
  assign mis = |imem_req_addr[1:0];

`ifdef IMEM_RESP_ERR_EN
  logic err_q, err_d;

  assign sel_word = (oor | mis) ? '0 : rd_word;
  assign imem_resp_err = err_q;

  always_comb begin
    err_d = err_q;
    if (fire) err_d = oor | mis;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) err_q <= 1'b0;
    else err_q <= err_d;
  end
`else
  logic unused_mis;

  assign unused_mis = mis;
  assign sel_word = oor ? INSN_NOP : rd_word;
`endif

  // Gated by reset so nothing is accepted while reset is held.
  assign imem_req_ready = reset_n && (state_q == IDLE);
  assign fire = imem_req_valid & imem_req_ready;
  assign imem_resp_valid = (state_q == RESP);
  assign imem_resp_data = data_q;

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    data_d = data_q;
    unique case (state_q)
      IDLE: begin
        if (fire) begin
          data_d = sel_word;
          cnt_d = LAT_CNT_W'(LATENCY - 1);
          state_d = (LATENCY > 1) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (cnt_q <= LAT_CNT_W'(1)) begin
          cnt_d = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - LAT_CNT_W'(1);
        end
      end
      RESP: begin
        if (imem_resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder at LATENCY=1 (idx 0) and 3 (idx 1).
// Honours IMEM_RESP_ERR_EN for the error output.
module tb_imem_responder;

`ifdef IMEM_RESP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset_n;
  logic [31:0] ra;
  logic [1:0] rv, rr, rdy, vld, err;
  logic [1:0][31:0] rdat;
  logic ld_we;
  logic [9:0] ld_addr;
  logic [31:0] ld_data;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  imem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u0 (
    .clk(clk),
    .reset_n(reset_n),
    .imem_req_valid(rv[0]),
    .imem_req_addr(ra),
    .imem_req_ready(rdy[0]),
    .imem_resp_valid(vld[0]),
    .imem_resp_data(rdat[0]),
    .imem_resp_ready(rr[0]),
    .ld_we(ld_we),
    .ld_addr(ld_addr),
    .ld_data(ld_data)
`ifdef IMEM_RESP_ERR_EN
    ,
    .imem_resp_err(err[0])
`endif
  );

  imem_responder #(.DEPTH_WORDS(1024), .LATENCY(3)) u1 (
    .clk(clk),
    .reset_n(reset_n),
    .imem_req_valid(rv[1]),
    .imem_req_addr(ra),
    .imem_req_ready(rdy[1]),
    .imem_resp_valid(vld[1]),
    .imem_resp_data(rdat[1]),
    .imem_resp_ready(rr[1]),
    .ld_we(ld_we),
    .ld_addr(ld_addr),
    .ld_data(ld_data)
`ifdef IMEM_RESP_ERR_EN
    ,
    .imem_resp_err(err[1])
`endif
  );

`ifndef IMEM_RESP_ERR_EN
  assign err = 2'b00;
`endif

  // All drivers start and end at posedge+1.
  task automatic load(input int idx, input logic [31:0] d);
    ld_we = 1'b1;
    ld_addr = 10'(idx);
    ld_data = d;
    @(posedge clk); #1;
    ld_we = 1'b0;
  endtask

  task automatic xact(input int s, input logic [31:0] addr,
                      output int lat, output logic [31:0] data,
                      output logic e, output bit rdy_seen,
                      output bit to);
    int n;
    to = 0;
    rdy_seen = 0;
    rv[s] = 1'b1;
    ra = addr;
    n = 0;
    @(negedge clk);
    while (!rdy[s] && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!rdy[s]) to = 1;
    @(posedge clk); #1;
    rv[s] = 1'b0;
    lat = 0;
    data = '0;
    e = 1'b0;
    while (!to) begin
      @(negedge clk);
      lat++;
      if (rdy[s]) rdy_seen = 1;
      if (vld[s]) begin
        data = rdat[s];
        e = err[s];
        break;
      end
      if (lat > 50) to = 1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      total++;
      if (rdy[s] !== 1'b0) begin
        bad++;
        $display("FAIL rst_ready[%0d] got=%b want=0", s, rdy[s]);
      end
      total++;
      if (vld[s] !== 1'b0) begin
        bad++;
        $display("FAIL rst_valid[%0d] got=%b want=0", s, vld[s]);
      end
      total++;
      if (rdat[s] !== 32'h0) begin
        bad++;
        $display("FAIL rst_data[%0d] got=%h want=0", s, rdat[s]);
      end
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      total++;
      if (rdy[s] !== 1'b1) begin
        bad++;
        $display("FAIL post_rst_ready[%0d] got=%b want=1", s, rdy[s]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_lat1;
    int lat; logic [31:0] d; logic e; bit rs, to;
    exp_q.push_back(32'hDEAD_BEEF);
    xact(0, 32'h14, lat, d, e, rs, to);
    total++;
    if (to || lat != 1) begin
      bad++;
      $display("FAIL lat1_latency got=%0d want=1 to=%0b", lat, to);
    end
    total++;
    if (d !== exp_q.pop_front()) begin
      bad++;
      $display("FAIL lat1_data got=%h want=deadbeef", d);
    end
    total++;
    if (rs) begin
      bad++;
      $display("FAIL lat1_ready_busy got=1 want=0");
    end
    @(negedge clk);
    total++;
    if (rdy[0] !== 1'b1 || vld[0] !== 1'b0) begin
      bad++;
      $display("FAIL lat1_idle rdy=%b vld=%b want 1/0", rdy[0], vld[0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_lat3;
    int lat; logic [31:0] d; logic e; bit rs, to;
    exp_q.push_back(32'h0000_0093);
    xact(1, 32'h0, lat, d, e, rs, to);
    total++;
    if (to || lat != 3) begin
      bad++;
      $display("FAIL lat3_latency got=%0d want=3 to=%0b", lat, to);
    end
    total++;
    if (d !== exp_q.pop_front()) begin
      bad++;
      $display("FAIL lat3_data got=%h want=00000093", d);
    end
    total++;
    if (rs) begin
      bad++;
      $display("FAIL lat3_ready_busy got=1 want=0");
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] first;
    rr[0] = 1'b0;
    exp_q.push_back(32'hDEAD_BEEF);
    exp_q.push_back(32'h0000_0093);
    rv[0] = 1'b1;
    ra = 32'h14;
    @(posedge clk); #1;
    ra = 32'h0;
    first = exp_q.pop_front();
    repeat (5) begin
      @(negedge clk);
      total++;
      if (vld[0] !== 1'b1 || rdat[0] !== first) begin
        bad++;
        $display("FAIL bp_hold vld=%b data=%h want 1/%h",
                 vld[0], rdat[0], first);
      end
      total++;
      if (rdy[0] !== 1'b0) begin
        bad++;
        $display("FAIL bp_no_accept rdy=%b want=0", rdy[0]);
      end
    end
    @(posedge clk); #1;
    rr[0] = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (rdy[0] !== 1'b1 || vld[0] !== 1'b0) begin
      bad++;
      $display("FAIL bp_release rdy=%b vld=%b want 1/0", rdy[0], vld[0]);
    end
    @(posedge clk); #1;
    rv[0] = 1'b0;
    @(negedge clk);
    total++;
    if (vld[0] !== 1'b1 || rdat[0] !== exp_q[0]) begin
      bad++;
      $display("FAIL bp_second vld=%b data=%h want 1/%h",
               vld[0], rdat[0], exp_q[0]);
    end
    void'(exp_q.pop_front());
    @(posedge clk); #1;
  endtask

  task automatic test_rw_order;
    int lat; logic [31:0] d; logic e; bit rs, to;
    exp_q.push_back(32'h2222_2222);
    fork
      xact(1, 32'h8, lat, d, e, rs, to);
      load(2, 32'h1111_1111);
    join
    total++;
    if (to || d !== exp_q.pop_front()) begin
      bad++;
      $display("FAIL rw_same_cycle got=%h want=22222222", d);
    end
    exp_q.push_back(32'h1111_1111);
    xact(1, 32'h8, lat, d, e, rs, to);
    total++;
    if (to || d !== exp_q.pop_front()) begin
      bad++;
      $display("FAIL rw_later got=%h want=11111111", d);
    end
  endtask

  task automatic test_range;
    int lat; logic [31:0] d; logic e; bit rs, to;
    logic [31:0] addrs[3] = '{32'h1000, 32'hFFFF_FFFC, 32'h6};
    logic [31:0] wants[3];
    wants[0] = ERR_EN ? 32'h0 : NOP;
    wants[1] = ERR_EN ? 32'h0 : NOP;
    wants[2] = ERR_EN ? 32'h0 : 32'h0000_0113;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 3; i++) begin
        exp_q.push_back(wants[i]);
        xact(s, addrs[i], lat, d, e, rs, to);
        total++;
        if (to || d !== exp_q.pop_front()) begin
          bad++;
          $display("FAIL range[%0d] addr=%h got=%h want=%h",
                   s, addrs[i], d, wants[i]);
        end
`ifdef IMEM_RESP_ERR_EN
        total++;
        if (e !== 1'b1) begin
          bad++;
          $display("FAIL err[%0d] addr=%h got=%b want=1", s, addrs[i], e);
        end
`endif
      end
`ifdef IMEM_RESP_ERR_EN
      exp_q.push_back(32'hDEAD_BEEF);
      xact(s, 32'h14, lat, d, e, rs, to);
      total++;
      if (to || e !== 1'b0 || d !== exp_q.pop_front()) begin
        bad++;
        $display("FAIL err_ok[%0d] err=%b data=%h want 0/deadbeef",
                 s, e, d);
      end
`endif
    end
  endtask

  task automatic test_reset_mid;
    int lat; logic [31:0] d; logic e; bit rs, to;
    rv[1] = 1'b1;
    ra = 32'h0;
    @(posedge clk); #1;
    rv[1] = 1'b0;
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (vld[1] !== 1'b0 || rdy[1] !== 1'b0) begin
      bad++;
      $display("FAIL midrst vld=%b rdy=%b want 0/0", vld[1], rdy[1]);
    end
    repeat (3) begin
      @(negedge clk);
      total++;
      if (vld[1] !== 1'b0) begin
        bad++;
        $display("FAIL midrst_drop vld=%b want=0", vld[1]);
      end
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    total++;
    if (rdy[1] !== 1'b1) begin
      bad++;
      $display("FAIL midrst_release rdy=%b want=1", rdy[1]);
    end
    @(posedge clk); #1;
    exp_q.push_back(32'hDEAD_BEEF);
    xact(1, 32'h14, lat, d, e, rs, to);
    total++;
    if (to || lat != 3 || d !== exp_q.pop_front()) begin
      bad++;
      $display("FAIL midrst_fresh lat=%0d data=%h want 3/deadbeef", lat, d);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    rv = 2'b00;
    rr = 2'b11;
    ra = '0;
    ld_we = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    test_reset();
    load(0, 32'h0000_0093);
    load(1, 32'h0000_0113);
    load(2, 32'h2222_2222);
    load(5, 32'hDEAD_BEEF);
    test_lat1();
    test_lat3();
    test_backpressure();
    test_rw_order();
    test_range();
    test_reset_mid();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_left got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory target that answers the fetch stage's imem request/response handshake.
- Accepts one request at a time on the req channel (valid/ready).
- Reads a word from an internal RAM array and returns it on the resp channel (valid/ready) after a fixed, parameterised latency.
- Holds the response under back-pressure. A loader write port fills the array from the testbench or boot logic.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array; power of two, ≥ 2.
- LATENCY, 1, cycles from req fire to first resp_valid; legal range 1..15.
- AW, $clog2(DEPTH_WORDS), word-index width (derived; not overridden).

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- imem_req_valid  in  1  request present
- imem_req_addr  in  32  byte address of instruction
- imem_req_ready  out  1  responder can accept a request
- imem_resp_valid  out  1  response data valid
- imem_resp_data  out  32  instruction word
- imem_resp_ready  in  1  consumer accepts response
- ld_we  in  1  loader write enable
- ld_addr  in  AW  loader word index
- ld_data  in  32  loader write data

Behaviour:
- Reset and clock: reset_n is synchronous, active-low; clock is clk. In reset, state=IDLE, imem_req_ready=0, imem_resp_valid=0, imem_resp_data=0, latency counter=0. Array contents are not cleared.
- FSM states:
  - IDLE: imem_req_ready=1. Fire = req_valid & req_ready. On fire, latch the array word, load cnt=LATENCY-1, go to WAIT (LATENCY>1) or RESP (LATENCY=1).
  - WAIT: req_ready=0, resp_valid=0. cnt decrements each cycle. Go to RESP when cnt reaches 1.
  - RESP: resp_valid=1, resp_data stable. On resp_valid & resp_ready, go to IDLE.
- Latency: resp_valid rises exactly LATENCY cycles after the req-fire edge.
- Throughput: back-to-back throughput is one request per LATENCY+1 cycles. There is no same-cycle req acceptance in RESP.
- Single outstanding: req_ready is high only in IDLE. A request presented in WAIT or RESP is not accepted and is not lost; the initiator keeps it asserted.
- Address decode: word index = imem_req_addr[AW+1:2]. addr[1:0] is ignored. Addresses ≥ DEPTH_WORDS*4 return NOP 32'h0000_0013.
- Read/write ordering: data is sampled from the array in the fire cycle (read-before-write). A loader write to the same word in the same cycle is not visible to that response. Later writes do not alter a pending response.
- Loader port: ld_we writes ld_data to ld_addr at the clock edge in any state. The write is visible to reads fired on later cycles.
- resp_ready while not RESP: ignored.
- Reset mid-transaction: a pending request or response is dropped; resp_valid=0 the cycle after the reset edge.
- Stability: resp_data and resp_valid must not change while resp_valid=1 and resp_ready=0.

Optional Feature:
- Macro: IMEM_RESP_ERR_EN.
- Defined:
  - Adds output imem_resp_err (1 bit), valid with imem_resp_valid.
  - err=1 when the latched address is misaligned (addr[1:0]!=0) or out of range; resp_data=0 in that case.
  - err resets to 0 and is held stable with the response.
- Undefined: no err port. Misaligned addresses silently word-align; out-of-range addresses return NOP.

Decomposition:
- Package imem_pkg:
  - XLEN=32
  - INSN_NOP=32'h0000_0013
  - typedef enum logic [1:0] {IDLE, WAIT, RESP} imem_rsp_state_t
  - LAT_CNT_W=4
- Sub-module imem_array: DEPTH_WORDS×32 array with one combinational read index and one synchronous write port (ld_*). The FSM, counter and output registers stay in imem_responder.

Test Plan:
- Load word 5 = 32'hDEAD_BEEF; LATENCY=1; req addr 0x14 with resp_ready=1 → req_ready drops next cycle; resp_valid=1 with data DEADBEEF exactly 1 cycle after fire; req_ready returns the cycle after resp fire.
- LATENCY=3; req addr 0x0 (word0=0x0000_0093) → resp_valid high exactly 3 cycles after fire; req_ready=0 throughout.
- Hold resp_ready=0 for 5 cycles in RESP, with a second req_valid asserted → resp_valid and data held constant, no second fire; release → second request accepted in the IDLE cycle.
- ld_we to word 2 (0x1111_1111) in the same cycle as req fire to 0x8 (old 0x2222_2222) → response 0x2222_2222; the next read of 0x8 → 0x1111_1111.
- Addr 0x1000 with DEPTH_WORDS=1024 → data 0x0000_0013. With IMEM_RESP_ERR_EN, data 0 and err=1; addr 0x6 also gives err=1.
- Assert reset_n=0 during WAIT → next cycle resp_valid=0, req_ready=0. After release, req_ready=1 and a fresh request completes normally.
